// File: rtl/mode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mode_sequencer_if
//  Description : Bundles the link/input requests, the vsync stream and the
//                mode/tick outputs that pass between the game logic, the
//                mode sequencer and the draw block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mode_sequencer_if;
  logic       vsync;
  logic       start;
  logic       restart;
  logic       game_over;
  logic [1:0] result;
  logic       link_err;
  logic [2:0] mode;
  logic       game_tick;
  logic       frame_start;

  // Requesting side: drives requests and vsync, observes the mode
  modport master (
    output vsync, start, restart, game_over, result, link_err,
    input  mode, game_tick, frame_start
  );

  // Sequencer side
  modport slave (
    input  vsync, start, restart, game_over, result, link_err,
    output mode, game_tick, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mode_sequencer
//  Description : Owns the game mode (MENU/GAME/WIN/LOSE/DRAW/ERROR). All mode
//                changes happen only on a detected vsync falling edge so the
//                draw block never switches screen mid-frame. Issues the
//                periodic game-logic tick while in GAME.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_sequencer #(
  parameter int TICK_FRAMES   = 8,
  parameter int RESULT_FRAMES = 180,
  parameter int ERROR_FRAMES  = 60,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  mode_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    GAME  = 3'd1,
    WIN   = 3'd2,
    LOSE  = 3'd3,
    DRAW  = 3'd4,
    ERROR = 3'd5
  } mode_t;

  localparam logic [CNT_W-1:0] c_tick_last   = CNT_W'(TICK_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_result_last = CNT_W'(RESULT_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_error_last  = CNT_W'(ERROR_FRAMES - 1);

  mode_t            mode_q;
  logic             vs_q;
  logic             fs_q;
  logic             tick_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic             start_pend_q,   start_pend_d;
  logic             restart_pend_q, restart_pend_d;
  logic             over_pend_q,    over_pend_d;
  logic [1:0]       res_q,          res_d;
  logic             in_result;

  assign in_result = (mode_q == WIN) || (mode_q == LOSE) || (mode_q == DRAW);

  // Pending requests including this cycle's pulse; a request the current
  // mode cannot use is dropped immediately rather than held for later.
  always_comb begin
    start_pend_d   = (start_pend_q   | bus.start)     & (mode_q == MENU);
    restart_pend_d = (restart_pend_q | bus.restart)   & in_result;
    over_pend_d    = (over_pend_q    | bus.game_over) & (mode_q == GAME);
    res_d          = res_q;
    if (bus.game_over && (mode_q == GAME)) res_d = bus.result;
  end

  // Frame detect, request latching and frame-synchronous mode sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= MENU;
      vs_q           <= 1'b1;
      fs_q           <= 1'b0;
      tick_q         <= 1'b0;
      cnt_q          <= '0;
      tick_cnt_q     <= '0;
      start_pend_q   <= 1'b0;
      restart_pend_q <= 1'b0;
      over_pend_q    <= 1'b0;
      res_q          <= 2'b00;
    end else begin
      vs_q           <= bus.vsync;
      fs_q           <= vs_q & ~bus.vsync;
      tick_q         <= 1'b0;
      start_pend_q   <= start_pend_d;
      restart_pend_q <= restart_pend_d;
      over_pend_q    <= over_pend_d;
      res_q          <= res_d;

      if (fs_q) begin
        // A link fault pre-empts everything; leaving a mode consumes or
        // drops every request, including one arriving in this very cycle.
        if ((mode_q != ERROR) && bus.link_err) begin
          mode_q         <= ERROR;
          cnt_q          <= '0;
          start_pend_q   <= 1'b0;
          restart_pend_q <= 1'b0;
          over_pend_q    <= 1'b0;
        end else begin
          case (mode_q)
            MENU: begin
              if (start_pend_d) begin
                mode_q       <= GAME;
                cnt_q        <= '0;
                tick_cnt_q   <= '0;
                start_pend_q <= 1'b0;
              end
            end
            GAME: begin
              if (over_pend_d) begin
                case (res_d)
                  2'b00:   mode_q <= WIN;
                  2'b01:   mode_q <= LOSE;
                  2'b10:   mode_q <= DRAW;
                  default: mode_q <= ERROR;
                endcase
                cnt_q       <= '0;
                over_pend_q <= 1'b0;
              end else if (tick_cnt_q == c_tick_last) begin
                tick_q     <= 1'b1;
                tick_cnt_q <= '0;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
            WIN, LOSE, DRAW: begin
              if (restart_pend_d) begin
                mode_q         <= MENU;
                cnt_q          <= '0;
                restart_pend_q <= 1'b0;
              end else if (cnt_q == c_result_last) begin
                mode_q <= MENU;
                cnt_q  <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            ERROR: begin
              // Recovery needs an unbroken run of fault-free frames
              if (bus.link_err) begin
                cnt_q <= '0;
              end else if (cnt_q == c_error_last) begin
                mode_q <= MENU;
                cnt_q  <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: begin
              mode_q <= MENU;
              cnt_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.game_tick   = tick_q;
  assign bus.frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_sequencer
//  Description : Self-checking bench for mode_sequencer. A frame-level model
//                tracks mode, pending requests and frame counts and predicts
//                mode, frame_start and game_tick at every vsync falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_sequencer;

  localparam int TICK = 8;
  localparam int RESF = 3;
  localparam int ERRF = 4;
  localparam int FLH  = 12;   // cycles of vsync high per frame

  localparam logic [2:0] M_MENU  = 3'd0;
  localparam logic [2:0] M_GAME  = 3'd1;
  localparam logic [2:0] M_WIN   = 3'd2;
  localparam logic [2:0] M_LOSE  = 3'd3;
  localparam logic [2:0] M_DRAW  = 3'd4;
  localparam logic [2:0] M_ERROR = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mode_sequencer_if bus ();

  mode_sequencer #(
    .TICK_FRAMES   (TICK),
    .RESULT_FRAMES (RESF),
    .ERROR_FRAMES  (ERRF),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- frame-level reference model ----------------
  logic [2:0] m_mode;
  int         m_game_frames, m_hold, m_ok;
  bit         p_start, p_restart, p_over;
  logic [1:0] p_res;
  int         last_tick;

  function automatic bit is_res(input logic [2:0] m);
    return (m == M_WIN) || (m == M_LOSE) || (m == M_DRAW);
  endfunction

  task automatic model_reset();
    m_mode = M_MENU; m_game_frames = 0; m_hold = 0; m_ok = 0;
    p_start = 0; p_restart = 0; p_over = 0; p_res = 2'b00;
  endtask

  task automatic model_req(input bit st, input bit rs, input bit go, input logic [1:0] res);
    if (st && m_mode == M_MENU) p_start = 1;
    if (rs && is_res(m_mode)) p_restart = 1;
    if (go && m_mode == M_GAME) begin p_over = 1; p_res = res; end
  endtask

  task automatic model_frame(input bit lerr, output bit tick);
    logic [2:0] nm;
    tick = 0;
    nm = m_mode;
    if (m_mode != M_ERROR && lerr) nm = M_ERROR;
    else if (m_mode == M_MENU) begin
      if (p_start) nm = M_GAME;
    end else if (m_mode == M_GAME) begin
      if (p_over) nm = (p_res == 2'b00) ? M_WIN : (p_res == 2'b01) ? M_LOSE :
                       (p_res == 2'b10) ? M_DRAW : M_ERROR;
      else begin
        m_game_frames++;
        tick = (m_game_frames % TICK) == 0;
      end
    end else if (is_res(m_mode)) begin
      if (p_restart) nm = M_MENU;
      else begin
        m_hold++;
        if (m_hold == RESF) nm = M_MENU;
      end
    end else begin
      if (lerr) m_ok = 0;
      else begin
        m_ok++;
        if (m_ok == ERRF) nm = M_MENU;
      end
    end
    if (nm != m_mode) begin
      p_start = 0; p_restart = 0; p_over = 0;
      m_game_frames = 0; m_hold = 0; m_ok = 0;
    end
    m_mode = nm;
  endtask

  // One full frame: vsync high with optional request pulses at given body
  // cycles (-1 = none), then a falling edge; st_fs/rs_fs pulse in the
  // frame_start cycle itself.
  task automatic frame(input int st_at, input int rs_at, input int go_at,
                       input logic [1:0] res, input bit lerr,
                       input bit st_fs, input bit rs_fs);
    int fs_cnt, tk_cnt;
    bit exp_tick;
    fs_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < FLH; i++) begin
      @(negedge clk);
      fs_cnt += int'(bus.frame_start); tk_cnt += int'(bus.game_tick);
      bus.vsync     = 1'b1;
      bus.link_err  = lerr;
      bus.start     = (i == st_at);
      bus.restart   = (i == rs_at);
      bus.game_over = (i == go_at);
      bus.result    = (i == go_at) ? res : 2'($urandom);
    end
    model_req(st_at >= 0, rs_at >= 0, go_at >= 0, res);
    @(negedge clk);
    fs_cnt += int'(bus.frame_start); tk_cnt += int'(bus.game_tick);
    bus.vsync = 1'b0; bus.start = 0; bus.restart = 0; bus.game_over = 0;
    @(negedge clk);
    fs_cnt += int'(bus.frame_start); tk_cnt += int'(bus.game_tick);
    n_chk++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++; $display("FAIL frame_start_timing: got %0b expected 1", bus.frame_start);
    end
    bus.start = st_fs; bus.restart = rs_fs; bus.result = 2'($urandom);
    model_req(st_fs, rs_fs, 1'b0, 2'b00);
    model_frame(lerr, exp_tick);
    @(negedge clk);
    fs_cnt += int'(bus.frame_start); tk_cnt += int'(bus.game_tick);
    bus.start = 0; bus.restart = 0;
    n_chk++;
    if (bus.mode !== m_mode) begin
      n_fail++; $display("FAIL mode: got %0d expected %0d", bus.mode, m_mode);
    end
    n_chk++;
    if (bus.game_tick !== exp_tick) begin
      n_fail++; $display("FAIL game_tick_timing: got %0b expected %0b", bus.game_tick, exp_tick);
    end
    @(negedge clk);
    fs_cnt += int'(bus.frame_start); tk_cnt += int'(bus.game_tick);
    n_chk++;
    if (fs_cnt !== 1) begin
      n_fail++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    n_chk++;
    if (tk_cnt !== int'(exp_tick)) begin
      n_fail++; $display("FAIL game_tick_count: got %0d expected %0d", tk_cnt, exp_tick);
    end
    last_tick = tk_cnt;
  endtask

  task automatic idle_frame(input bit lerr);
    frame(-1, -1, -1, 2'b00, lerr, 1'b0, 1'b0);
  endtask

  task automatic check_mode(input string name, input logic [2:0] exp);
    n_chk++;
    if (bus.mode !== exp) begin
      n_fail++; $display("FAIL %s: got %0d expected %0d", name, bus.mode, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.vsync = 1'b1; bus.start = 0; bus.restart = 0; bus.game_over = 0;
    bus.result = 2'b00; bus.link_err = 0;
    repeat (3) @(negedge clk);
    check_mode("reset_mode", M_MENU);
    n_chk++;
    if (bus.game_tick !== 1'b0 || bus.frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got tick=%0b fs=%0b expected 0 0", bus.game_tick, bus.frame_start);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    int ticks;
    ticks = 0;
    for (int f = 0; f < 3; f++) begin
      idle_frame(1'b0);
      ticks += last_tick;
      check_mode("idle_mode", M_MENU);
    end
    n_chk++;
    if (ticks !== 0) begin n_fail++; $display("FAIL idle_ticks: got %0d expected 0", ticks); end
  endtask

  task automatic test_start_ticks();
    int ticks;
    ticks = 0;
    frame(5, -1, -1, 2'b00, 1'b0, 1'b0, 1'b0);
    check_mode("start_enters_game", M_GAME);
    for (int f = 1; f <= 17; f++) begin
      idle_frame(1'b0);
      ticks += last_tick;
      if (f == 8) begin
        n_chk++;
        if (last_tick !== 1) begin n_fail++; $display("FAIL first_tick: got %0d expected 1", last_tick); end
      end
    end
    n_chk++;
    if (ticks !== 2) begin n_fail++; $display("FAIL tick_total_17: got %0d expected 2", ticks); end
  endtask

  task automatic test_result();
    frame(-1, -1, 4, 2'b01, 1'b0, 1'b0, 1'b0);
    check_mode("game_over_lose", M_LOSE);
    idle_frame(1'b0); idle_frame(1'b0);
    check_mode("lose_held", M_LOSE);
    idle_frame(1'b0);
    check_mode("lose_expiry", M_MENU);
    frame(3, -1, -1, 2'b00, 1'b0, 1'b0, 1'b0);
    frame(-1, -1, 6, 2'b01, 1'b0, 1'b0, 1'b0);
    check_mode("lose_again", M_LOSE);
    frame(-1, 3, -1, 2'b00, 1'b0, 1'b0, 1'b0);
    check_mode("restart_early", M_MENU);
  endtask

  task automatic test_error();
    frame(2, -1, -1, 2'b00, 1'b0, 1'b0, 1'b0);
    frame(-1, -1, 7, 2'b11, 1'b0, 1'b0, 1'b0);
    check_mode("invalid_result", M_ERROR);
    idle_frame(1'b0);
    idle_frame(1'b1);
    for (int f = 0; f < 3; f++) idle_frame(1'b0);
    check_mode("error_recount", M_ERROR);
    idle_frame(1'b0);
    check_mode("error_recovered", M_MENU);
  endtask

  task automatic test_simultaneous();
    frame(5, -1, 5, 2'b00, 1'b1, 1'b0, 1'b0);
    check_mode("link_err_priority", M_ERROR);
    for (int f = 0; f < ERRF + 2; f++) idle_frame(1'b0);
    check_mode("no_stale_start", M_MENU);
    frame(-1, -1, -1, 2'b00, 1'b0, 1'b1, 1'b0);
    check_mode("start_at_frame_start", M_GAME);
    frame(-1, -1, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    check_mode("win", M_WIN);
    idle_frame(1'b0); idle_frame(1'b0);
    frame(-1, -1, -1, 2'b00, 1'b0, 1'b0, 1'b1);
    check_mode("win_expiry_drops_restart", M_MENU);
  endtask

  task automatic test_stuck_vsync();
    int fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      fs_cnt += int'(bus.frame_start);
      bus.vsync = 1'b1;
      bus.start = (i == 10);
    end
    model_req(1'b1, 1'b0, 1'b0, 2'b00);
    n_chk++;
    if (fs_cnt !== 0) begin n_fail++; $display("FAIL stuck_fs: got %0d expected 0", fs_cnt); end
    check_mode("stuck_mode", M_MENU);
    idle_frame(1'b0);
    check_mode("stuck_start_kept", M_GAME);
  endtask

  task automatic test_reset_mid_game();
    int fs_cnt;
    fs_cnt = 0;
    for (int f = 0; f < 5; f++) idle_frame(1'b0);
    @(negedge clk);
    bus.vsync = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_mode("rst_mid_game", M_MENU);
    n_chk++;
    if (bus.game_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %0b expected 0", bus.game_tick); end
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fs_cnt += int'(bus.frame_start);
    end
    n_chk++;
    if (fs_cnt !== 0) begin n_fail++; $display("FAIL rst_no_fs: got %0d expected 0", fs_cnt); end
    idle_frame(1'b0);
    check_mode("rst_stays_menu", M_MENU);
  endtask

  task automatic test_random();
    for (int f = 0; f < 80; f++) begin
      frame(($urandom_range(0, 1) == 0) ? int'($urandom_range(0, FLH - 1)) : -1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FLH - 1)) : -1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FLH - 1)) : -1,
            2'($urandom), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_idle();
    test_start_ticks();
    test_result();
    test_error();
    test_simultaneous();
    test_stuck_vsync();
    test_reset_mid_game();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Owns the `game_mode` value that drives `draw`, and sequences the game through MENU, GAME, WIN, LOSE, DRAW and ERROR.
- Every mode change is frame-synchronous: it takes effect only at the falling edge of the VGA vsync, so `draw` never switches screens mid-frame.
- Issues the periodic game-logic step pulse while in GAME, and sits between the input/link logic and `draw`.

Parameters:
- TICK_FRAMES, 8: frames per game_tick pulse while in GAME (≥1).
- RESULT_FRAMES, 180: frames a WIN/LOSE/DRAW screen is held before the automatic return to MENU (≥1).
- ERROR_FRAMES, 60: consecutive frames with link_err low required to leave ERROR (≥1).
- CNT_W, 8: width of the frame counter; must hold max(TICK_FRAMES, RESULT_FRAMES, ERROR_FRAMES).

Ports:
- clk, in, 1: system clock, 75 MHz.
- rst, in, 1: synchronous, active-high reset.
- vsync, in, 1: vsync from the vga_if stream feeding `draw`.
- start, in, 1: one-cycle request to start a game (menu click).
- restart, in, 1: one-cycle request to leave a result screen early.
- game_over, in, 1: one-cycle pulse from game logic, qualified by result.
- result, in, 2: 00 WIN, 01 LOSE, 10 DRAW, 11 invalid; sampled only when game_over is high.
- link_err, in, 1: level, high while the inter-board link is faulty.
- mode, out, game_mode: current mode to `draw`.
- game_tick, out, 1: one-cycle game-logic step enable.
- frame_start, out, 1: one-cycle pulse per detected frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - mode=MENU; game_tick=0; frame_start=0.
  - Frame counter=0; all pending requests cleared; vsync history register=1.
- Frame detect:
  - vs_q <= vsync each cycle.
  - frame_start is registered high for exactly one cycle, the cycle after (vs_q==1 && vsync==0).
  - No other pulse occurs until the next falling edge.
- Request capture: start, restart and game_over (with its result) set sticky pending flags in any cycle.
  - Flags clear only when consumed at a frame_start, or when the current mode cannot use them: start ignored outside MENU; restart ignored outside WIN/LOSE/DRAW; game_over ignored outside GAME.
  - A second game_over before consumption overwrites the latched result.
- Transitions, evaluated only in the cycle frame_start is high; mode is updated on that same edge.
- Priority: link_err > game_over > restart > start > counter expiry.
- Any mode except ERROR, with link_err=1: go to ERROR, counter=0, all pending cleared.
- MENU: start pending → GAME, counter=0.
- GAME: game_over pending → WIN/LOSE/DRAW per the latched result, counter=0. Latched result 11 → ERROR.
- WIN/LOSE/DRAW:
  - restart pending → MENU.
  - Otherwise counter+1; at counter==RESULT_FRAMES-1 → MENU, counter=0.
- ERROR:
  - link_err=1 → counter=0.
  - link_err=0 → counter+1; at counter==ERROR_FRAMES-1 → MENU, counter=0.
- game_tick:
  - In GAME, with no transition out of GAME on that frame, tick_cnt increments on each frame_start.
  - When tick_cnt reaches TICK_FRAMES-1, game_tick is registered high for one cycle (coincident with the cycle after frame_start) and tick_cnt wraps to 0.
  - tick_cnt is 0 on entry to GAME, so the first tick occurs TICK_FRAMES frames after entry.
  - No tick is issued in any other mode.
- Simultaneous events:
  - start and frame_start in the same cycle: the request is captured and applied at that same frame_start.
  - Request arriving in the frame_start cycle of a leaving transition: dropped.
- vsync stuck (never falls): mode frozen, no ticks, requests remain pending.
- Reset mid-frame: the next frame_start requires a fresh 1→0 edge of vsync after reset.

Test Plan:
- Reset then idle 3 frames → mode=MENU throughout; exactly 3 frame_start pulses, each 1 cycle wide; game_tick never high.
- start pulse mid-frame 2 → mode stays MENU until next vsync falling edge + 1 cycle, then GAME; with TICK_FRAMES=8, first game_tick at the 8th frame_start after entry, then every 8 frames.
- In GAME, game_over with result=01 → LOSE at next frame_start. With RESULT_FRAMES=3, mode=MENU at the 3rd following frame_start. Repeat with restart at frame 1 → MENU at the 2nd frame_start.
- game_over with result=11 → ERROR. link_err held low, ERROR_FRAMES=4 → MENU after 4 frames. A link_err blip at frame 2 restarts the count, giving 4 more frames.
- Same-cycle start, game_over and link_err=1 in MENU → next frame: ERROR, all pending cleared, no GAME entry after recovery without a new start.
- rst asserted mid-GAME with tick_cnt=5 → next cycle: mode=MENU, game_tick=0. After release, no frame_start until a new vsync falling edge.
